// File: rtl/servo_pkg.sv
// Shared types and default timing constants for the servo ramp scheduler.
// Also holds the pulse-width clamp helper used by the command and slew paths.
package servo_pkg;

    localparam int unsigned DEF_MIN_DUR    = 50000;
    localparam int unsigned DEF_MAX_DUR    = 100000;
    localparam int unsigned DEF_CENTER_DUR = 75000;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_e;

    // Saturate a pulse width into [lo, hi] using unsigned compares.
    function automatic logic [31:0] clamp_dur(
        input logic [31:0] v,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/pwm_generator.sv
// Free-running PWM output for one channel: high while the period
// counter is below high_dur, period is total_dur+1 cycles.
module PWM_Generator (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] high_dur,
    input  logic [31:0] total_dur,
    output logic        pwm
);

    logic [31:0] cnt;

    // Period counter and registered output level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 32'd0;
            pwm <= 1'b0;
        end else begin
            cnt <= (cnt >= total_dur) ? 32'd0 : cnt + 32'd1;
            pwm <= (cnt < high_dur);
        end
    end

endmodule

// File: rtl/servo_slew_step.sv
// One slew step: move current toward target by at most step per frame.
// A zero step means "jump straight to target".
module servo_slew_step
    import servo_pkg::*;
#(
    parameter int unsigned MIN_DUR = DEF_MIN_DUR,
    parameter int unsigned MAX_DUR = DEF_MAX_DUR
) (
    input  logic [31:0] current,
    input  logic [31:0] target,
    input  logic [31:0] step,
    output logic [31:0] next
);

    localparam logic [31:0] MIN_V = 32'(MIN_DUR);
    localparam logic [31:0] MAX_V = 32'(MAX_DUR);

    logic [31:0] diff;
    logic [31:0] raw;

    // Distance to target decides between a full jump and a partial move.
    always_comb begin
        diff = (target >= current) ? (target - current) : (current - target);
        if (step == 32'd0 || diff <= step) begin
            raw = target;
        end else if (target > current) begin
            raw = current + step;
        end else begin
            raw = current - step;
        end
        next = clamp_dur(raw, MIN_V, MAX_V);
    end

endmodule

// File: rtl/servo_ramp_scheduler.sv
// Multi-channel servo pulse-width scheduler with per-frame slew limiting.
// Commands land in IDLE; one channel is stepped per cycle after frame_start.
module servo_ramp_scheduler
    import servo_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned FRAME_TICKS = 1000000,
    parameter int unsigned MIN_DUR     = DEF_MIN_DUR,
    parameter int unsigned MAX_DUR     = DEF_MAX_DUR,
    parameter int unsigned CENTER_DUR  = DEF_CENTER_DUR,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CHW-1:0]    cmd_ch,
    input  logic [31:0]       cmd_target,
    input  logic [31:0]       cmd_step,
    output logic [NCH*32-1:0] high_dur,
    output logic [31:0]       total_dur,
    output logic              frame_start,
    output logic              all_settled,
    output logic              cmd_err,
    output logic [NCH-1:0]    pwm
);

    localparam logic [31:0]    LAST_TICK = 32'(FRAME_TICKS - 1);
    localparam logic [31:0]    MIN_V     = 32'(MIN_DUR);
    localparam logic [31:0]    MAX_V     = 32'(MAX_DUR);
    localparam logic [31:0]    CENTER_V  = 32'(CENTER_DUR);
    localparam logic [CHW-1:0] LAST_IDX  = CHW'(NCH - 1);

    logic [31:0]    frame_cnt;
    state_e         state_q;
    logic [CHW-1:0] idx_q;
    logic [31:0]    cur_q [NCH];
    logic [31:0]    tgt_q [NCH];
    logic [31:0]    stp_q [NCH];
    logic [31:0]    slew_next;
    logic           cmd_fire;
    logic           ch_ok;
    logic           all_eq;

    assign cmd_ready = (state_q == ST_IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign ch_ok     = (32'(cmd_ch) < 32'(NCH));
    assign total_dur = LAST_TICK;

    // Frame counter; frame_start marks the cycle after the last tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt   <= 32'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (frame_cnt == LAST_TICK);
            frame_cnt   <= (frame_cnt == LAST_TICK) ? 32'd0
                                                    : frame_cnt + 32'd1;
        end
    end

    // Update pass sequencer: one channel per cycle after each frame_start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_q <= ST_UPDATE;
                        idx_q   <= '0;
                    end
                end
                ST_UPDATE: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    servo_slew_step #(
        .MIN_DUR (MIN_DUR),
        .MAX_DUR (MAX_DUR)
    ) u_slew (
        .current (cur_q[idx_q]),
        .target  (tgt_q[idx_q]),
        .step    (stp_q[idx_q]),
        .next    (slew_next)
    );

    // Per-channel target/step capture and current-position stepping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NCH); i++) begin
                cur_q[i] <= CENTER_V;
                tgt_q[i] <= CENTER_V;
                stp_q[i] <= 32'd0;
            end
        end else begin
            if (cmd_fire && ch_ok) begin
                tgt_q[cmd_ch] <= clamp_dur(cmd_target, MIN_V, MAX_V);
                stp_q[cmd_ch] <= cmd_step;
            end
            if (state_q == ST_UPDATE) begin
                cur_q[idx_q] <= slew_next;
            end
        end
    end

    // Every channel sitting at its target.
    always_comb begin
        all_eq = 1'b1;
        for (int i = 0; i < int'(NCH); i++) begin
            if (cur_q[i] != tgt_q[i]) all_eq = 1'b0;
        end
    end

    // Registered status: settled flag and bad-channel error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            all_settled <= 1'b1;
            cmd_err     <= 1'b0;
        end else begin
            all_settled <= all_eq;
            cmd_err     <= cmd_fire && !ch_ok;
        end
    end

    for (genvar g = 0; g < int'(NCH); g++) begin : g_ch
        assign high_dur[32*g +: 32] = cur_q[g];

        PWM_Generator u_pwm (
            .clk       (clk),
            .reset_n   (reset_n),
            .high_dur  (cur_q[g]),
            .total_dur (total_dur),
            .pwm       (pwm[g])
        );
    end

endmodule
